// File: rtl/handshake_constant_match.sv
// Checks each accepted token against a fixed constant and emits a 1-bit match result through a 2-entry FIFO.
// Optional define HANDSHAKE_CONSTANT_MATCH_CAPTURE_EN adds err_data, which holds the first mismatching token.
module handshake_constant_match #(
  parameter int unsigned                 DATA_WIDTH  = 37,
  parameter logic [DATA_WIDTH-1:0]       CONST_VALUE = DATA_WIDTH'(37'h0DC2E0480B),
  parameter int unsigned                 CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  err,
`ifdef HANDSHAKE_CONSTANT_MATCH_CAPTURE_EN
  output logic [DATA_WIDTH-1:0] err_data,
`endif
  input  logic                  clr
);

  localparam int unsigned PTR_WIDTH   = 1;
  localparam int unsigned COUNT_WIDTH = 2;
  localparam logic [COUNT_WIDTH-1:0] FULL = COUNT_WIDTH'(2);

  logic [1:0]             mem_q, mem_d;
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   push, pop, match_c;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop       = outs_valid & outs_ready;
  assign ins_ready = (count_q != FULL) | pop;
  assign push      = ins_valid & ins_ready;
  assign match_c   = (ins == CONST_VALUE);

  // FIFO next state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = match_c;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // outs/outs_valid are registered copies of the post-update FIFO head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outs       <= 1'b0;
      outs_valid <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      outs       <= mem_d[rd_ptr_d];
      outs_valid <= (count_d != '0);
    end
  end

  // Saturating event counters and sticky error; clr takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_count    <= '0;
      mismatch_count <= '0;
      err            <= 1'b0;
    end else if (clr) begin
      match_count    <= '0;
      mismatch_count <= '0;
      err            <= 1'b0;
    end else if (push) begin
      if (match_c) begin
        if (!(&match_count)) begin
          match_count <= match_count + CNT_WIDTH'(1);
        end
      end else begin
        if (!(&mismatch_count)) begin
          mismatch_count <= mismatch_count + CNT_WIDTH'(1);
        end
        err <= 1'b1;
      end
    end
  end

`ifdef HANDSHAKE_CONSTANT_MATCH_CAPTURE_EN
  // Only the first mismatch since reset/clr is captured (err still low).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_data <= '0;
    end else if (clr) begin
      err_data <= '0;
    end else if (push && !match_c && !err) begin
      err_data <= ins;
    end
  end
`endif

endmodule

// File: tb/tb_handshake_constant_match.sv
// Randomized self-checking bench for handshake_constant_match against a queue-based reference model.
module tb_handshake_constant_match;
  localparam int unsigned DW   = 37;
  localparam int unsigned CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;
  localparam logic [DW-1:0] K  = 37'h0DC2E0480B;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] ins = '0;
  logic          ins_valid = 1'b0;
  logic          ins_ready;
  logic          outs, outs_valid;
  logic          outs_ready = 1'b0;
  logic [CW-1:0] match_count, mismatch_count;
  logic          err;
  logic          clr = 1'b0;
`ifdef HANDSHAKE_CONSTANT_MATCH_CAPTURE_EN
  logic [DW-1:0] err_data;
  logic [DW-1:0] m_err_data = '0;
`endif

  int checks = 0;
  int passed = 0;

  // Reference model state
  bit q[$];
  int m_match = 0, m_mismatch = 0;
  bit m_err = 1'b0;
  bit m_acc = 1'b0;
  logic dut_acc = 1'b0;

  always #5 clk = ~clk;

  handshake_constant_match #(.DATA_WIDTH(DW), .CONST_VALUE(K), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready),
    .match_count(match_count), .mismatch_count(mismatch_count), .err(err),
`ifdef HANDSHAKE_CONSTANT_MATCH_CAPTURE_EN
    .err_data(err_data),
`endif
    .clr(clr)
  );

  function automatic logic [DW-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return DW'(r);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_match = 0; m_mismatch = 0; m_err = 1'b0;
`ifdef HANDSHAKE_CONSTANT_MATCH_CAPTURE_EN
    m_err_data = '0;
`endif
  endfunction

  // One clock: drive at negedge, advance model from pre-edge state, return #1 after posedge.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit ordy, input bit c);
    bit pop, rdy;
    @(negedge clk);
    ins_valid = v; ins = d; outs_ready = ordy; clr = c;
    #1;
    dut_acc = ins_valid & ins_ready;
    pop = (q.size() > 0) && ordy;
    rdy = (q.size() < 2) || pop;
    m_acc = v && rdy;
    if (pop) void'(q.pop_front());
    if (m_acc) q.push_back(d == K);
    if (c) begin
      m_match = 0; m_mismatch = 0; m_err = 1'b0;
`ifdef HANDSHAKE_CONSTANT_MATCH_CAPTURE_EN
      m_err_data = '0;
`endif
    end else if (m_acc) begin
      if (d == K) begin
        if (m_match < MAXC) m_match++;
      end else begin
        if (m_mismatch < MAXC) m_mismatch++;
`ifdef HANDSHAKE_CONSTANT_MATCH_CAPTURE_EN
        if (!m_err) m_err_data = d;
`endif
        m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({outs_valid, outs, ins_ready, err} !== 4'b0010)
      $display("FAIL reset_flags: got %b expected 0010", {outs_valid, outs, ins_ready, err});
    else passed++;
    checks++;
    if ({match_count, mismatch_count} !== '0)
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", match_count, mismatch_count);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_match();
    cycle(1'b1, K, 1'b1, 1'b0);
    checks++;
    if ({outs_valid, outs} !== 2'b11) $display("FAIL match_out: got %b expected 11", {outs_valid, outs});
    else passed++;
    checks++;
    if (match_count !== CW'(1) || err !== 1'b0)
      $display("FAIL match_count: got cnt=%0d err=%b expected cnt=1 err=0", match_count, err);
    else passed++;
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_mismatch();
    logic [DW-1:0] first;
    cycle(1'b1, '0, 1'b1, 1'b0);
    checks++;
    if ({outs_valid, outs} !== 2'b10) $display("FAIL mismatch_out: got %b expected 10", {outs_valid, outs});
    else passed++;
    checks++;
    if (mismatch_count !== CW'(1) || err !== 1'b1)
      $display("FAIL mismatch_count: got cnt=%0d err=%b expected cnt=1 err=1", mismatch_count, err);
    else passed++;
`ifdef HANDSHAKE_CONSTANT_MATCH_CAPTURE_EN
    checks++;
    if (err_data !== '0) $display("FAIL err_data_zero: got %h expected 0", err_data);
    else passed++;
    cycle(1'b0, '0, 1'b1, 1'b1);
    first = K ^ DW'(37'h1_0000_0100);
    cycle(1'b1, first, 1'b1, 1'b0);
    cycle(1'b1, rand_data() | DW'(1) ^ K, 1'b1, 1'b0);
    checks++;
    if (err_data !== first) $display("FAIL err_data_first: got %h expected %h", err_data, first);
    else passed++;
`else
    first = '0;
    cycle(1'b0, first, 1'b1, 1'b0);
`endif
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    int acc = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, (i % 2 == 0) ? K : '0, 1'b0, 1'b0);
      if (dut_acc) acc++;
    end
    checks++;
    if (acc !== 2) $display("FAIL bp_accepted: got %0d expected 2", acc);
    else passed++;
    checks++;
    if (ins_ready !== 1'b0) $display("FAIL bp_ready: got %b expected 0", ins_ready);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (outs_valid !== 1'b1 || outs !== ((i == 0) ? 1'b1 : 1'b0))
        $display("FAIL bp_drain%0d: got v=%b d=%b expected v=1 d=%b", i, outs_valid, outs, (i == 0));
      else passed++;
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (outs_valid !== 1'b0) $display("FAIL bp_empty: got %b expected 0", outs_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    cycle(1'b1, K, 1'b0, 1'b0);
    cycle(1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      d = ($urandom_range(1) == 1) ? K : rand_data();
      cycle(1'b1, d, 1'b1, 1'b0);
      checks++;
      if (dut_acc !== 1'b1 || q.size() != 2 || outs_valid !== 1'b1 || outs !== q[0])
        $display("FAIL b2b_%0d: got acc=%b v=%b d=%b expected acc=1 v=1 d=%b", i, dut_acc, outs_valid, outs, q[0]);
      else passed++;
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, K, 1'b1, 1'b0);
    checks++;
    if (match_count !== CW'(MAXC)) $display("FAIL sat_count: got %0d expected %0d", match_count, MAXC);
    else passed++;
    cycle(1'b1, '0, 1'b1, 1'b0);
    cycle(1'b1, K, 1'b1, 1'b1);
    checks++;
    if (match_count !== '0 || mismatch_count !== '0 || err !== 1'b0)
      $display("FAIL clr_priority: got %0d/%0d err=%b expected 0/0 err=0", match_count, mismatch_count, err);
    else passed++;
    checks++;
    if ({outs_valid, outs} !== 2'b11) $display("FAIL clr_token: got %b expected 11", {outs_valid, outs});
    else passed++;
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(1) == 1) ? K : rand_data();
      cycle($urandom_range(3) != 0, d, $urandom_range(2) != 0, $urandom_range(40) == 0);
      checks++;
      if (dut_acc !== m_acc || outs_valid !== (q.size() > 0) || (q.size() > 0 && outs !== q[0]) ||
          match_count !== CW'(m_match) || mismatch_count !== CW'(m_mismatch) || err !== m_err
`ifdef HANDSHAKE_CONSTANT_MATCH_CAPTURE_EN
          || err_data !== m_err_data
`endif
         ) begin
        if (bad < 10)
          $display("FAIL random_%0d: got acc=%b v=%b d=%b m=%0d mm=%0d e=%b expected acc=%b v=%b m=%0d mm=%0d e=%b",
                   i, dut_acc, outs_valid, outs, match_count, mismatch_count, err,
                   m_acc, q.size() > 0, m_match, m_mismatch, m_err);
        bad++;
      end else passed++;
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, '0, 1'b0, 1'b0);
    cycle(1'b1, K, 1'b0, 1'b0);
    @(negedge clk);
    ins_valid = 1'b0; outs_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({outs_valid, ins_ready, err} !== 3'b010 || match_count !== '0 || mismatch_count !== '0)
      $display("FAIL reset_mid: got v=%b r=%b e=%b m=%0d mm=%0d expected v=0 r=1 e=0 m=0 mm=0",
               outs_valid, ins_ready, err, match_count, mismatch_count);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (outs_valid !== 1'b0) $display("FAIL reset_no_emit: got %b expected 0", outs_valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
